// File: rtl/reg_file_2r1w_if.sv
// ============================================================================
// Module      : reg_file_2r1w_if
// Description : Write port and two read ports of the 2R1W register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_2r1w_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [WIDTH-1:0]     wdata;
  logic [WIDTH/8-1:0]   wbe;
  logic                 re1;
  logic [ADDR_W-1:0]    raddr1;
  logic [WIDTH-1:0]     rdata1;
  logic                 re2;
  logic [ADDR_W-1:0]    raddr2;
  logic [WIDTH-1:0]     rdata2;

  modport master (
    output we, waddr, wdata, wbe, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, wbe, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ============================================================================
// Module      : reg_file_2r1w
// Description : DEPTH x WIDTH register file, one byte-enabled write port and
//               two registered read ports. Define RF_BYPASS_EN for write-first
//               read-during-write; otherwise reads are read-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_2r1w_if.slave  rf
);

  localparam int c_NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata1;
  logic [WIDTH-1:0] r_rdata2;

  logic             w_waddr_ok;
  logic             w_raddr1_ok;
  logic             w_raddr2_ok;
  logic             w_wr_valid;
  logic [WIDTH-1:0] w_wold;
  logic [WIDTH-1:0] w_wmerged;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  // Register 0 is treated as unaddressable when hardwired to zero.
  always_comb begin
    w_waddr_ok  = (int'(rf.waddr)  < DEPTH) && !((ZERO_REG == 1) && (rf.waddr  == '0));
    w_raddr1_ok = (int'(rf.raddr1) < DEPTH) && !((ZERO_REG == 1) && (rf.raddr1 == '0));
    w_raddr2_ok = (int'(rf.raddr2) < DEPTH) && !((ZERO_REG == 1) && (rf.raddr2 == '0));
    w_wr_valid  = rf.we && w_waddr_ok;
    w_wold      = w_waddr_ok ? r_mem[rf.waddr] : '0;
  end

  generate
    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_byte
      assign w_wmerged[8*gi +: 8] = rf.wbe[gi] ? rf.wdata[8*gi +: 8] : w_wold[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_rd1 = w_raddr1_ok ? r_mem[rf.raddr1] : '0;
    w_rd2 = w_raddr2_ok ? r_mem[rf.raddr2] : '0;
`ifdef RF_BYPASS_EN
    // A valid write implies a valid read address, so matching is sufficient.
    if (w_wr_valid && (rf.raddr1 == rf.waddr)) begin
      w_rd1 = w_wmerged;
    end
    if (w_wr_valid && (rf.raddr2 == rf.waddr)) begin
      w_rd2 = w_wmerged;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      if (w_wr_valid) begin
        r_mem[rf.waddr] <= w_wmerged;
      end
      if (rf.re1) begin
        r_rdata1 <= w_rd1;
      end
      if (rf.re2) begin
        r_rdata2 <= w_rd2;
      end
    end
  end

  assign rf.rdata1 = r_rdata1;
  assign rf.rdata2 = r_rdata2;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Directed and random checks of two register-file instances
//               (DEPTH=24/ZERO_REG=1 and DEPTH=32/ZERO_REG=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_2r1w;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_2r1w_if #(.WIDTH(32), .ADDR_W(5)) ifa ();
  reg_file_2r1w_if #(.WIDTH(32), .ADDR_W(5)) ifb ();

  reg_file_2r1w #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .rf    (ifa.slave)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .rf    (ifb.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          depth [2] = '{24, 32};
  bit          zreg  [2] = '{1'b1, 1'b0};
  logic [31:0] m     [2][32];
  logic [31:0] e1    [2];
  logic [31:0] e2    [2];

`ifdef RF_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  function automatic bit addr_ok(int k, int a);
    return (a < depth[k]) && !(zreg[k] && a == 0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_a_rd1"}, ifa.rdata1, e1[0]);
    chk({tag, "_a_rd2"}, ifa.rdata2, e2[0]);
    chk({tag, "_b_rd1"}, ifb.rdata1, e1[1]);
    chk({tag, "_b_rd2"}, ifb.rdata2, e2[1]);
  endtask

  // One clock cycle: drive both instances, advance the model, sample after the edge.
  task automatic cyc(input bit rn, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input bit r1, input logic [4:0] a1,
                     input bit r2, input logic [4:0] a2);
    logic [31:0] nv;
    bit          wv;
    reset = rn;
    ifa.we = we; ifa.waddr = wa; ifa.wdata = wd; ifa.wbe = be;
    ifa.re1 = r1; ifa.raddr1 = a1; ifa.re2 = r2; ifa.raddr2 = a2;
    ifb.we = we; ifb.waddr = wa; ifb.wdata = wd; ifb.wbe = be;
    ifb.re1 = r1; ifb.raddr1 = a1; ifb.re2 = r2; ifb.raddr2 = a2;
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        for (int i = 0; i < 32; i++) m[k][i] = '0;
        e1[k] = '0;
        e2[k] = '0;
      end else begin
        wv = we && addr_ok(k, int'(wa));
        nv = wv ? merge(m[k][wa], wd, be) : '0;
        if (r1) e1[k] = (c_BYPASS && wv && a1 == wa) ? nv : (addr_ok(k, int'(a1)) ? m[k][a1] : '0);
        if (r2) e2[k] = (c_BYPASS && wv && a2 == wa) ? nv : (addr_ok(k, int'(a2)) ? m[k][a2] : '0);
        if (wv) m[k][wa] = nv;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m[k][i] = '0;
      e1[k] = '0;
      e2[k] = '0;
    end

    // Reset held for two edges, then reads of 0, 5, 31 on both ports.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("reset");
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 0);
    check_all("rst_rd0");
    cyc(1, 0, 0, 0, 0, 1, 5, 1, 5);
    check_all("rst_rd5");
    cyc(1, 0, 0, 0, 0, 1, 31, 1, 31);
    check_all("rst_rd31");

    // Full write, then read on port 1 only.
    cyc(1, 1, 7, 32'hAFAFAFAF, 4'hF, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 7, 0, 3);
    check_all("full_wr");
    chk("full_wr_const", ifa.rdata1, 32'hAFAFAFAF);

    // Byte-enable merge.
    cyc(1, 1, 3, 32'h11223344, 4'hF, 0, 0, 0, 0);
    cyc(1, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 1, 3);
    check_all("byte_en");
    chk("byte_en_const", ifa.rdata2, 32'h11BB33DD);
    cyc(1, 1, 3, 32'h99999999, 4'h0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0);
    check_all("wbe_zero");

    // Zero register and out-of-range writes.
    cyc(1, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 7);
    check_all("zero_reg");
    chk("zero_reg_const", ifa.rdata1, 32'h0);
    cyc(1, 1, 30, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 30, 1, 3);
    check_all("oob");
    chk("oob_const", ifa.rdata1, 32'h0);

    // Read-during-write on address 9.
    cyc(1, 1, 9, 32'h00000001, 4'hF, 0, 0, 0, 0);
    cyc(1, 1, 9, 32'h12345678, 4'hF, 1, 9, 1, 9);
    check_all("rdw");
    chk("rdw_const", ifa.rdata1, c_BYPASS ? 32'h12345678 : 32'h00000001);
    cyc(1, 0, 0, 0, 0, 1, 9, 0, 0);
    check_all("rdw_next");
    chk("rdw_next_const", ifa.rdata1, 32'h12345678);

    // Reset coinciding with a read of address 7.
    cyc(0, 0, 0, 0, 0, 1, 7, 1, 7);
    check_all("mid_rst");
    cyc(1, 0, 0, 0, 0, 1, 7, 1, 7);
    check_all("mid_rst_rd7");
    chk("mid_rst_const", ifb.rdata1, 32'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) != 0),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
